ram_sync_nrmw: RTL and testbench

Parametrised multi-port synchronous RAM with NUM_RD read ports and NUM_WR write ports, replacing the fixed 1r1w/2r1w/2r2w/4r1w/4r2w/6r2w variants. It adds the following over those variants:
- per-port read enables with output hold;
- a selectable read-during-write mode (old data or forwarded new data);
- deterministic write-collision priority;
- a hardware clear sequencer that initialises every entry after reset or on request.

It sits under register files, rename tables and predictor tables in the core.

---
 rtl/ram_sync_nrmw_pkg.sv | 18 +
 rtl/ram_clear_seq.sv | 46 ++++
 rtl/ram_sync_nrmw.sv | 103 ++++++++++
 tb/tb_ram_sync_nrmw.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sync_nrmw_pkg.sv
// Shared encodings for the multi-port synchronous RAM and its clear sequencer.
package ram_sync_nrmw_pkg;

  // Default port geometry used when the instantiating block gives none
  localparam int ADDR_LEN = 5;
  localparam int DATA_LEN = 32;

  // Read-during-write behaviour of the RAM
  localparam int RAM_RD_OLD = 0;
  localparam int RAM_RD_NEW = 1;

  // Clear sequencer states
  typedef enum logic {
    RAM_ST_INIT  = 1'b0,
    RAM_ST_READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every entry once after reset or a clear request,
// owning the array while it does so and flagging that with busy.
module ram_clear_seq
  import ram_sync_nrmw_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_LEN,
  parameter int DATA_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  clear,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DATA_DEPTH - 1);

  ram_state_e            state;
  logic [ADDR_WIDTH-1:0] ptr;

  // State, pointer and busy advance together; clear always restarts at entry 0
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state <= RAM_ST_INIT;
      ptr   <= '0;
      busy  <= 1'b1;
    end else if (clear) begin
      state <= RAM_ST_INIT;
      ptr   <= '0;
      busy  <= 1'b1;
    end else if (state == RAM_ST_INIT) begin
      if (ptr == LAST_PTR) begin
        state <= RAM_ST_READY;
        ptr   <= '0;
        busy  <= 1'b0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  assign clr_we   = (state == RAM_ST_INIT);
  assign clr_addr = ptr;

endmodule

// File: rtl/ram_sync_nrmw.sv
// Parametrised multi-port synchronous RAM: NUM_RD registered read ports with
// enables, NUM_WR write ports with highest-index-wins collisions, optional
// write forwarding and a hardware clear sequence after reset or on request.
module ram_sync_nrmw
  import ram_sync_nrmw_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = ADDR_LEN,
  parameter int BRAM_DATA_WIDTH = DATA_LEN,
  parameter int DATA_DEPTH      = 32,
  parameter int NUM_RD          = 2,
  parameter int NUM_WR          = 1,
  parameter int BYPASS          = RAM_RD_OLD,
  parameter logic [BRAM_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                reset_x,
  input  logic                                clear,
  output logic                                busy,
  input  logic [NUM_RD-1:0]                   re,
  input  logic [NUM_RD*BRAM_ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*BRAM_DATA_WIDTH-1:0]   rdata,
  input  logic [NUM_WR-1:0]                   we,
  input  logic [NUM_WR*BRAM_ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_WR*BRAM_DATA_WIDTH-1:0]   wdata
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  // The array spans the full address space so every address indexes it
  // directly; entries at or above DATA_DEPTH are never written or returned.
  localparam int MEM_SIZE = 1 << AW;

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  ram_clear_seq #(
    .ADDR_WIDTH(AW),
    .DATA_DEPTH(DATA_DEPTH)
  ) u_clear_seq (
    .clk     (clk),
    .reset_x (reset_x),
    .clear   (clear),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .busy    (busy)
  );

  logic [DW-1:0] mem [MEM_SIZE];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW + 1)'(DATA_DEPTH);
  endfunction

  // The sequencer owns the array while clearing; otherwise user writes land
  // in port order so the highest-index port's write is the one that sticks
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (we[w] && in_range(waddr[w*AW +: AW])) begin
          mem[waddr[w*AW +: AW]] <= wdata[w*DW +: DW];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] word;
    logic [DW-1:0] q;

    assign addr = raddr[r*AW +: AW];

    // Stored word, replaced by the winning same-address write when forwarding
    always_comb begin
      word = mem[addr];
      if (BYPASS == RAM_RD_NEW) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (we[w] && (waddr[w*AW +: AW] == addr)) begin
            word = wdata[w*DW +: DW];
          end
        end
      end
    end

    // Enabled reads load zero while clearing or out of range; disabled ports hold
    always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
        q <= '0;
      end else if (re[r]) begin
        if (busy || !in_range(addr)) begin
          q <= '0;
        end else begin
          q <= word;
        end
      end
    end

    assign rdata[r*DW +: DW] = q;
  end

endmodule

// File: tb/tb_ram_sync_nrmw.sv
// Self-checking bench for ram_sync_nrmw: two 32-entry 2r2w instances that
// differ only in read-during-write mode share stimulus, and a 24-entry 1r1w
// instance exercises out-of-range addressing.
module tb_ram_sync_nrmw;

  logic clk = 1'b0;
  logic reset_x;

  // Shared stimulus for the 32-entry old-data and forwarding instances
  logic        clear;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        busy0, busy1;
  logic [31:0] rdata0, rdata1;

  // Stimulus for the 24-entry instance
  logic        clear2;
  logic [0:0]  re2;
  logic [4:0]  raddr2;
  logic [0:0]  we2;
  logic [4:0]  waddr2;
  logic [15:0] wdata2;
  logic        busy2;
  logic [15:0] rdata2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          dut;
    int          port;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] e00;
    logic [15:0] e01;
    logic [15:0] e10;
    logic [15:0] e11;
  } vec_t;

  vec_t vecs[14];

  ram_sync_nrmw #(
    .BRAM_ADDR_WIDTH(5), .BRAM_DATA_WIDTH(16), .DATA_DEPTH(32),
    .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .INIT_VALUE(16'h005A)
  ) dut0 (
    .clk(clk), .reset_x(reset_x), .clear(clear), .busy(busy0),
    .re(re), .raddr(raddr), .rdata(rdata0),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  ram_sync_nrmw #(
    .BRAM_ADDR_WIDTH(5), .BRAM_DATA_WIDTH(16), .DATA_DEPTH(32),
    .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .INIT_VALUE(16'h005A)
  ) dut1 (
    .clk(clk), .reset_x(reset_x), .clear(clear), .busy(busy1),
    .re(re), .raddr(raddr), .rdata(rdata1),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  ram_sync_nrmw #(
    .BRAM_ADDR_WIDTH(5), .BRAM_DATA_WIDTH(16), .DATA_DEPTH(24),
    .NUM_RD(1), .NUM_WR(1), .BYPASS(0), .INIT_VALUE(16'h005A)
  ) dut2 (
    .clk(clk), .reset_x(reset_x), .clear(clear2), .busy(busy2),
    .re(re2), .raddr(raddr2), .rdata(rdata2),
    .we(we2), .waddr(waddr2), .wdata(wdata2)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Port 0/1 select a read port, port 2 selects busy
  function automatic logic [15:0] getOut(int d, int p);
    logic [15:0] v;
    v = '0;
    case (d)
      0: v = (p == 0) ? rdata0[15:0] : (p == 1) ? rdata0[31:16] : {15'd0, busy0};
      1: v = (p == 0) ? rdata1[15:0] : (p == 1) ? rdata1[31:16] : {15'd0, busy1};
      default: v = (p == 2) ? {15'd0, busy2} : rdata2;
    endcase
    return v;
  endfunction

  task automatic checkOutput(string nm, int d, int p, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d port%0d actual=%h required=%h", nm, d, p, act, exp);
    end
  endtask

  task automatic pushExp(string nm, int d, int p, logic [15:0] v);
    exp_t e;
    e.name = nm;
    e.dut  = d;
    e.port = p;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  // Advance one edge, then settle and compare everything queued for that edge
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput(e.name, e.dut, e.port, getOut(e.dut, e.port), e.exp);
    end
  endtask

  task automatic setIdle();
    clear = 1'b0; re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    clear2 = 1'b0; re2 = '0; raddr2 = '0; we2 = '0; waddr2 = '0; wdata2 = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    re = v.re; raddr = v.raddr; we = v.we; waddr = v.waddr; wdata = v.wdata;
    pushExp("vec_p0", 0, 0, v.e00);
    pushExp("vec_p1", 0, 1, v.e01);
    pushExp("vec_p0", 1, 0, v.e10);
    pushExp("vec_p1", 1, 1, v.e11);
  endtask

  // Both 32-entry instances expect the same word on both ports
  task automatic pushBoth(string nm, logic [15:0] p0, logic [15:0] p1);
    pushExp(nm, 0, 0, p0);
    pushExp(nm, 0, 1, p1);
    pushExp(nm, 1, 0, p0);
    pushExp(nm, 1, 1, p1);
  endtask

  initial begin
    // Fields: re, raddr{p1,p0}, we, waddr{p1,p0}, wdata{p1,p0}, dut0 p0/p1, dut1 p0/p1
    vecs[0]  = '{2'b00, {5'd5, 5'd4},  2'b11, {5'd5, 5'd4}, {16'h0055, 16'h0044}, 16'h005A, 16'h005A, 16'h005A, 16'h005A};
    vecs[1]  = '{2'b11, {5'd5, 5'd4},  2'b00, 10'd0,        32'd0,                16'h0044, 16'h0055, 16'h0044, 16'h0055};
    vecs[2]  = '{2'b00, {5'd4, 5'd5},  2'b00, 10'd0,        32'd0,                16'h0044, 16'h0055, 16'h0044, 16'h0055};
    vecs[3]  = '{2'b10, {5'd4, 5'd5},  2'b00, 10'd0,        32'd0,                16'h0044, 16'h0044, 16'h0044, 16'h0044};
    vecs[4]  = '{2'b01, {5'd4, 5'd5},  2'b00, 10'd0,        32'd0,                16'h0055, 16'h0044, 16'h0055, 16'h0044};
    vecs[5]  = '{2'b01, {5'd4, 5'd7},  2'b01, {5'd0, 5'd7}, {16'h0000, 16'h1234}, 16'h005A, 16'h0044, 16'h1234, 16'h0044};
    vecs[6]  = '{2'b01, {5'd4, 5'd7},  2'b00, 10'd0,        32'd0,                16'h1234, 16'h0044, 16'h1234, 16'h0044};
    vecs[7]  = '{2'b11, {5'd3, 5'd3},  2'b11, {5'd3, 5'd3}, {16'hBBBB, 16'hAAAA}, 16'h005A, 16'h005A, 16'hBBBB, 16'hBBBB};
    vecs[8]  = '{2'b11, {5'd3, 5'd3},  2'b00, 10'd0,        32'd0,                16'hBBBB, 16'hBBBB, 16'hBBBB, 16'hBBBB};
    vecs[9]  = '{2'b11, {5'd3, 5'd9},  2'b11, {5'd9, 5'd9}, {16'hDDDD, 16'hCCCC}, 16'h005A, 16'hBBBB, 16'hDDDD, 16'hBBBB};
    vecs[10] = '{2'b11, {5'd7, 5'd9},  2'b00, 10'd0,        32'd0,                16'hDDDD, 16'h1234, 16'hDDDD, 16'h1234};
    vecs[11] = '{2'b11, {5'd12, 5'd13}, 2'b10, {5'd12, 5'd0}, {16'h0C0C, 16'h0000}, 16'h005A, 16'h005A, 16'h005A, 16'h0C0C};
    vecs[12] = '{2'b11, {5'd4, 5'd12}, 2'b00, 10'd0,        32'd0,                16'h0C0C, 16'h0044, 16'h0C0C, 16'h0044};
    vecs[13] = '{2'b01, {5'd0, 5'd13}, 2'b00, {5'd0, 5'd13}, {16'h0000, 16'hFFFF}, 16'h005A, 16'h0044, 16'h005A, 16'h0044};

    reset_x = 1'b0;
    setIdle();

    // Reset state
    step();
    for (int d = 0; d < 3; d++) pushExp("rst_busy", d, 2, 16'd1);
    pushBoth("rst_rdata", 16'd0, 16'd0);
    pushExp("rst_rdata", 2, 0, 16'd0);
    step();

    // Initial clear sequence: 32 edges for the big instances, 24 for the small one
    reset_x = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      re = 2'b11;
      raddr = {5'(i + 1), 5'(i)};
      pushExp("init_busy", 0, 2, (i < 32) ? 16'd1 : 16'd0);
      pushExp("init_busy", 1, 2, (i < 32) ? 16'd1 : 16'd0);
      pushExp("init_busy", 2, 2, (i < 24) ? 16'd1 : 16'd0);
      pushBoth("init_rd_busy", 16'd0, 16'd0);
      step();
    end

    // Every entry holds the clear value
    for (int a = 0; a < 32; a += 2) begin
      re = 2'b11;
      raddr = {5'(a + 1), 5'(a)};
      pushBoth("init_value", 16'h005A, 16'h005A);
      step();
    end

    // Table: enables/hold, read-during-write, collisions, forwarding gating
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      step();
    end
    setIdle();

    // Out-of-range addressing on the 24-entry instance
    we2 = 1'b1; waddr2 = 5'd30; wdata2 = 16'h0077; re2 = 1'b1; raddr2 = 5'd30;
    pushExp("oor_rdw30", 2, 0, 16'd0);
    step();
    waddr2 = 5'd24; wdata2 = 16'h2424; raddr2 = 5'd24;
    pushExp("oor_rdw24", 2, 0, 16'd0);
    step();
    we2 = 1'b0; raddr2 = 5'd30;
    pushExp("oor_rd30", 2, 0, 16'd0);
    step();
    raddr2 = 5'd24;
    pushExp("oor_rd24", 2, 0, 16'd0);
    step();
    for (int a = 0; a < 24; a++) begin
      raddr2 = 5'(a);
      pushExp("oor_unchanged", 2, 0, 16'h005A);
      step();
    end
    re2 = 1'b0; we2 = 1'b1; waddr2 = 5'd23; wdata2 = 16'h2323;
    pushExp("oor_hold", 2, 0, 16'h005A);
    step();
    we2 = 1'b0; re2 = 1'b1; raddr2 = 5'd23;
    pushExp("oor_last_entry", 2, 0, 16'h2323);
    step();
    raddr2 = 5'd31;
    pushExp("oor_rd31", 2, 0, 16'd0);
    step();
    setIdle();

    // Clear mid-operation
    we = 2'b11; waddr = {5'd20, 5'd10}; wdata = {16'h2020, 16'h0099};
    pushBoth("pre_clr_hold", 16'h005A, 16'h0044);
    step();
    we = 2'b00; re = 2'b11; raddr = {5'd20, 5'd10};
    pushBoth("pre_clr_rd", 16'h0099, 16'h2020);
    step();
    re = 2'b00; clear = 1'b1;
    pushExp("clr_busy", 0, 2, 16'd1);
    pushExp("clr_busy", 1, 2, 16'd1);
    step();
    clear = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      re = 2'b11;
      raddr = {5'd11, 5'd10};
      we = (k == 3) ? 2'b01 : 2'b00;
      waddr = {5'd0, 5'd11};
      wdata = {16'h0000, 16'h0077};
      pushExp("clr_busy", 0, 2, (k < 32) ? 16'd1 : 16'd0);
      pushExp("clr_busy", 1, 2, (k < 32) ? 16'd1 : 16'd0);
      pushBoth("clr_rd_zero", 16'd0, 16'd0);
      step();
    end
    we = 2'b00;
    raddr = {5'd11, 5'd10};
    pushBoth("post_clr_rd", 16'h005A, 16'h005A);
    step();
    raddr = {5'd4, 5'd20};
    pushBoth("post_clr_rd2", 16'h005A, 16'h005A);
    step();

    // Reset during a clear sequence
    re = 2'b00; we = 2'b01; waddr = {5'd0, 5'd20}; wdata = {16'h0000, 16'h2020};
    step();
    we = 2'b00; clear = 1'b1;
    pushExp("clr2_busy", 0, 2, 16'd1);
    step();
    clear = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pushExp("clr2_busy", 0, 2, 16'd1);
      pushExp("clr2_hold", 0, 0, 16'h005A);
      step();
    end
    #2;
    reset_x = 1'b0;
    #1;
    checkOutput("midrst_busy", 0, 2, getOut(0, 2), 16'd1);
    checkOutput("midrst_rdata", 0, 0, getOut(0, 0), 16'd0);
    checkOutput("midrst_rdata", 0, 1, getOut(0, 1), 16'd0);
    checkOutput("midrst_rdata", 1, 0, getOut(1, 0), 16'd0);
    @(posedge clk);
    #1;
    reset_x = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      pushExp("rst2_busy", 0, 2, (k < 32) ? 16'd1 : 16'd0);
      step();
    end
    re = 2'b11; raddr = {5'd10, 5'd20};
    pushBoth("rst2_rd", 16'h005A, 16'h005A);
    step();
    setIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
